inst_decode_ctrl: RTL and testbench
===================================

INST_DECODE_CTRL -- requirements
Module: inst_decode_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; only 32 is supported.
REQ-002 SHALL have port i_clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port i_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port i_flush  input  1  synchronous kill of all held instructions.
REQ-005 SHALL have port i_valid  input  1  upstream instruction valid.
REQ-006 SHALL have port o_ready  output  1  decoder can accept this cycle.
REQ-007 SHALL have port i_inst  input  32  fetched instruction word.
REQ-008 SHALL have port i_pc  input  32  PC of i_inst.
REQ-009 SHALL have port o_valid  output  1  decoded instruction valid.
REQ-010 SHALL have port i_ready  input  1  downstream accepts this cycle.
REQ-011 SHALL have port o_inst, o_pc  output  32 each  registered copies of the accepted word and PC.
REQ-012 SHALL have port o_format  output  5  one-hot {j,u,b,s,i}; all zero for R-type or illegal.
REQ-013 SHALL have port o_immediate  output  32  sign-extended immediate for o_inst.
REQ-014 SHALL have port o_illegal  output  1  opcode unrecognised or i_inst[1:0] != 2'b11.

Function
REQ-015 Decode on i_inst[6:2] SHALL be: 01101, 00101 -> u; 11011 -> j; 11001, 00000, 00100, 00011, 11100 -> i; 01000 -> s; 11000 -> b; 01100 -> R (format zero); anything else -> illegal.
REQ-016 o_immediate SHALL be produced by an instance of the codebase immediate_generator driven by the held instruction and o_format; zero when o_illegal or R-type.
REQ-017 A transfer in SHALL occur when i_valid && o_ready; a transfer out when o_valid && i_ready.
REQ-018 Latency SHALL be exactly 1 cycle: word accepted at edge N appears on outputs after edge N, with o_valid high, when the buffer was empty or drained at N.
REQ-019 Storage SHALL be a 2-entry skid buffer (output register + skid register); states EMPTY, ONE, FULL.
REQ-020 Transitions: EMPTY-in->ONE; ONE-in-only->FULL; ONE-out-only->EMPTY; ONE-in&out->ONE; FULL-out->ONE (skid entry moves to output register in order); FULL never accepts.
REQ-021 o_ready SHALL be a register output, high in EMPTY and ONE, low in FULL; never combinationally dependent on i_ready.
REQ-022 Sustained throughput SHALL be one instruction per cycle while i_ready stays high.
REQ-023 Outputs SHALL hold stable while o_valid && !i_ready.
REQ-024 Illegal instructions SHALL pass downstream in order with o_illegal=1; they are not dropped.
REQ-025 i_flush SHALL, at the next edge, force state EMPTY and o_valid=0, discarding any same-cycle input transfer and both held entries; flush wins over every simultaneous event.
REQ-026 Decode (format, illegal, immediate) SHALL be computed at capture and stored with each entry, not recomputed after the output register.

Reset
REQ-027 While i_rst_n=0: state EMPTY, o_valid=0, o_ready=0, o_inst=0, o_pc=0, o_format=0, o_immediate=0, o_illegal=0.
REQ-028 o_ready SHALL rise on the first rising edge after i_rst_n deasserts.
REQ-029 Reset asserted mid-transfer SHALL discard all entries immediately, without waiting for a clock edge.

Verification
REQ-030 Accept 0xFFF00093 at pc 0x100, i_ready=1 -> next cycle o_valid=1, o_format=00001, o_immediate=0xFFFFFFFF, o_pc=0x100.
REQ-031 Stream 0x0020A423, 0xFE000EE3, 0x123450B7 back-to-back, i_ready=1 -> immediates 0x00000008, 0xFFFFFFFC, 0x12345000, formats s, b, u on consecutive cycles.
REQ-032 Hold i_ready=0, offer 3 words -> first two accepted, o_ready low after second, third held upstream; release i_ready -> all three emerge in order with no loss or duplication.
REQ-033 Accept 0x00000000 -> o_illegal=1, o_format=0, o_immediate=0; accept 0x002081B3 (add) -> o_illegal=0, o_format=0.
REQ-034 Buffer FULL, assert i_flush with i_valid=1 -> next cycle o_valid=0, o_ready=1, input word not delivered.
REQ-035 Pull i_rst_n low mid-stream between edges -> o_valid=0 immediately; release -> o_ready=1 after one edge, next word decodes correctly.

Source files
------------

// File: rtl/inst_decode_ctrl.sv
// Instruction decode stage: classifies the fetched word, builds its
// immediate, and holds it in a two-entry skid buffer so o_ready is a flop.

// Builds the sign-extended immediate selected by a one-hot {j,u,b,s,i} format.
module immediate_generator (
    input  logic [31:7] inst,
    input  logic [4:0]  format,
    output logic [31:0] immediate
);

    // Priority order is irrelevant because format is one-hot or zero.
    always_comb begin
        immediate = '0;
        if (format[0]) begin
            immediate = {{20{inst[31]}}, inst[31:20]};
        end else if (format[1]) begin
            immediate = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        end else if (format[2]) begin
            immediate = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
        end else if (format[3]) begin
            immediate = {inst[31:12], 12'b0};
        end else if (format[4]) begin
            immediate = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
        end
    end

endmodule

module inst_decode_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_flush,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [31:0]     i_inst,
    input  logic [XLEN-1:0] i_pc,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [31:0]     o_inst,
    output logic [XLEN-1:0] o_pc,
    output logic [4:0]      o_format,
    output logic [XLEN-1:0] o_immediate,
    output logic            o_illegal
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0]     inst;
        logic [XLEN-1:0] pc;
        logic [4:0]      format;
        logic [XLEN-1:0] immediate;
        logic            illegal;
    } entry_t;

    state_t state;
    state_t state_next;
    logic   ready_q;
    entry_t out_q;
    entry_t skid_q;
    entry_t captured;

    logic        in_fire;
    logic        out_fire;
    logic        load_out_from_in;
    logic        load_out_from_skid;
    logic        load_skid;
    logic [4:0]  dec_format;
    logic        dec_illegal;
    logic [31:0] dec_immediate;

    assign in_fire  = i_valid && ready_q;
    assign out_fire = (state != EMPTY) && i_ready;

    // Classify the incoming word by opcode; illegal words carry no format.
    always_comb begin
        dec_format  = '0;
        dec_illegal = 1'b0;
        if (i_inst[1:0] != 2'b11) begin
            dec_illegal = 1'b1;
        end else begin
            case (i_inst[6:2])
                5'b01101, 5'b00101:                             dec_format = 5'b01000;
                5'b11011:                                       dec_format = 5'b10000;
                5'b11001, 5'b00000, 5'b00100, 5'b00011, 5'b11100: dec_format = 5'b00001;
                5'b01000:                                       dec_format = 5'b00010;
                5'b11000:                                       dec_format = 5'b00100;
                5'b01100:                                       dec_format = 5'b00000;
                default:                                        dec_illegal = 1'b1;
            endcase
        end
    end

    // Immediate is built from the word being captured so each entry stores it.
    immediate_generator u_immediate_generator (
        .inst      (i_inst[31:7]),
        .format    (dec_format),
        .immediate (dec_immediate)
    );

    assign captured = '{
        inst:      i_inst,
        pc:        i_pc,
        format:    dec_format,
        immediate: dec_immediate,
        illegal:   dec_illegal
    };

    // Next-state and buffer load controls; flush overrides everything.
    always_comb begin
        state_next         = state;
        load_out_from_in   = 1'b0;
        load_out_from_skid = 1'b0;
        load_skid          = 1'b0;
        case (state)
            EMPTY: begin
                if (in_fire) begin
                    state_next       = ONE;
                    load_out_from_in = 1'b1;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    load_out_from_in = 1'b1;
                end else if (in_fire) begin
                    state_next = FULL;
                    load_skid  = 1'b1;
                end else if (out_fire) begin
                    state_next = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    state_next         = ONE;
                    load_out_from_skid = 1'b1;
                end
            end
            default: state_next = EMPTY;
        endcase
        if (i_flush) begin
            state_next         = EMPTY;
            load_out_from_in   = 1'b0;
            load_out_from_skid = 1'b0;
            load_skid          = 1'b0;
        end
    end

    // State register; o_ready is registered from the next state, not from i_ready.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= EMPTY;
            ready_q <= 1'b0;
        end else begin
            state   <= state_next;
            ready_q <= (state_next != FULL);
        end
    end

    // Output and skid registers holding decoded entries in arrival order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            out_q  <= '0;
            skid_q <= '0;
        end else begin
            if (load_out_from_in) begin
                out_q <= captured;
            end else if (load_out_from_skid) begin
                out_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= captured;
            end
        end
    end

    assign o_ready     = ready_q;
    assign o_valid     = (state != EMPTY);
    assign o_inst      = out_q.inst;
    assign o_pc        = out_q.pc;
    assign o_format    = out_q.format;
    assign o_immediate = out_q.immediate;
    assign o_illegal   = out_q.illegal;

endmodule

// File: tb/tb_inst_decode_ctrl.sv
// Bench for inst_decode_ctrl: queue-based reference model compared every
// cycle, plus directed literal expectations.
module tb_inst_decode_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        valid_in = 1'b0;
    logic        ready_in = 1'b0;
    logic [31:0] inst_in = '0;
    logic [31:0] pc_in = '0;
    logic        ready_out;
    logic        valid_out;
    logic        illegal;
    logic [31:0] inst_out;
    logic [31:0] pc_out;
    logic [31:0] imm;
    logic [4:0]  fmt;

    always #5 clk = ~clk;

    inst_decode_ctrl #(.XLEN(32)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_flush     (flush),
        .i_valid     (valid_in),
        .o_ready     (ready_out),
        .i_inst      (inst_in),
        .i_pc        (pc_in),
        .o_valid     (valid_out),
        .i_ready     (ready_in),
        .o_inst      (inst_out),
        .o_pc        (pc_out),
        .o_format    (fmt),
        .o_immediate (imm),
        .o_illegal   (illegal)
    );

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [4:0]  fmt;
        logic        ill;
    } entry_t;

    entry_t q[$];
    logic   ready_m = 1'b0;
    bit     in_f;
    bit     out_f;
    int     passed = 0;
    int     total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Reference decode: RISC-V immediate rules written as integer arithmetic.
    function automatic entry_t model_decode(input logic [31:0] w, input logic [31:0] p);
        entry_t e;
        int s;
        s = w;
        e.inst = w;
        e.pc   = p;
        e.fmt  = 5'b0;
        e.ill  = 1'b0;
        e.imm  = 32'h0;
        if (w[1:0] != 2'b11) e.ill = 1'b1;
        else begin
            case (w[6:2])
                5'h0D, 5'h05:                      e.fmt = 5'b01000;
                5'h1B:                             e.fmt = 5'b10000;
                5'h19, 5'h00, 5'h04, 5'h03, 5'h1C: e.fmt = 5'b00001;
                5'h08:                             e.fmt = 5'b00010;
                5'h18:                             e.fmt = 5'b00100;
                5'h0C:                             e.fmt = 5'b00000;
                default:                           e.ill = 1'b1;
            endcase
        end
        case (e.fmt)
            5'b00001: e.imm = s >>> 20;
            5'b00010: e.imm = (s >>> 25) * 32 + int'(w[11:7]);
            5'b00100: e.imm = (s >>> 31) * 4096 + int'(w[7]) * 2048
                              + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
            5'b01000: e.imm = w & 32'hFFFFF000;
            5'b10000: e.imm = (s >>> 31) * 1048576 + int'(w[19:12]) * 4096
                              + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
            default:  e.imm = 32'h0;
        endcase
        return e;
    endfunction

    // Model: FIFO of at most two entries, ready when fewer than two held.
    always @(posedge clk) begin
        if (rst_n) begin
            in_f  = valid_in && ready_m;
            out_f = (q.size() > 0) && ready_in;
            if (flush) q.delete();
            else begin
                if (out_f) void'(q.pop_front());
                if (in_f) q.push_back(model_decode(inst_in, pc_in));
            end
            ready_m = (q.size() < 2);
        end
    end

    always @(negedge rst_n) begin
        q.delete();
        ready_m = 1'b0;
    end

    // Per-cycle comparison of DUT outputs against the model.
    always @(posedge clk) begin
        #1;
        check("ready", ready_out, ready_m);
        check("valid", valid_out, q.size() != 0);
        if (q.size() != 0) begin
            check("inst", inst_out, q[0].inst);
            check("pc", pc_out, q[0].pc);
            check("format", fmt, q[0].fmt);
            check("immediate", imm, q[0].imm);
            check("illegal", illegal, q[0].ill);
        end
    end

    task automatic send(input logic [31:0] w, input logic [31:0] p);
        bit took;
        took = 1'b0;
        valid_in = 1'b1;
        inst_in  = w;
        pc_in    = p;
        for (int n = 0; n < 20 && !took; n++) begin
            took = ready_out;
            @(negedge clk);
        end
        if (!took) begin
            total++;
            $display("FAIL send_timeout: inst 0x%08h not accepted, required within 20 cycles", w);
        end
        valid_in = 1'b0;
    endtask

    logic [31:0] words [3] = '{32'h0020A423, 32'hFE000EE3, 32'h123450B7};
    logic [31:0] imms  [3] = '{32'h00000008, 32'hFFFFFFFC, 32'h12345000};
    logic [4:0]  fmts  [3] = '{5'b00010, 5'b00100, 5'b01000};

    initial begin
        repeat (2) @(negedge clk);
        check("rst_ready", ready_out, 0);
        check("rst_valid", valid_out, 0);
        check("rst_inst", inst_out, 0);
        check("rst_pc", pc_out, 0);
        check("rst_format", fmt, 0);
        check("rst_imm", imm, 0);
        check("rst_illegal", illegal, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", ready_out, 1);
        ready_in = 1'b1;

        send(32'hFFF00093, 32'h100);
        check("i_valid", valid_out, 1);
        check("i_format", fmt, 5'b00001);
        check("i_imm", imm, 32'hFFFFFFFF);
        check("i_pc", pc_out, 32'h100);

        for (int k = 0; k < 3; k++) begin
            send(words[k], 32'h200 + 32'(4 * k));
            check("stream_imm", imm, imms[k]);
            check("stream_format", fmt, fmts[k]);
        end
        repeat (2) @(negedge clk);

        send(32'h00000000, 32'h300);
        check("zero_illegal", illegal, 1);
        check("zero_format", fmt, 0);
        check("zero_imm", imm, 0);
        send(32'h002081B3, 32'h304);
        check("add_illegal", illegal, 0);
        check("add_format", fmt, 0);
        send(32'h8000006F, 32'h308);
        check("jal_format", fmt, 5'b10000);
        check("jal_imm", imm, 32'hFFF00000);
        send(32'h00000012, 32'h30C);
        check("low_bits_illegal", illegal, 1);
        repeat (2) @(negedge clk);

        ready_in = 1'b0;
        send(32'h00100093, 32'h400);
        check("skid_ready_one", ready_out, 1);
        send(32'h00200113, 32'h404);
        check("skid_ready_full", ready_out, 0);
        valid_in = 1'b1;
        inst_in  = 32'h00300193;
        pc_in    = 32'h408;
        repeat (3) begin
            @(negedge clk);
            check("hold_inst", inst_out, 32'h00100093);
            check("hold_ready", ready_out, 0);
        end
        ready_in = 1'b1;
        send(32'h00300193, 32'h408);
        check("drain_third", inst_out, 32'h00300193);
        repeat (2) @(negedge clk);

        ready_in = 1'b0;
        send(32'h00400213, 32'h500);
        send(32'h00500293, 32'h504);
        valid_in = 1'b1;
        inst_in  = 32'h00600313;
        pc_in    = 32'h508;
        flush    = 1'b1;
        @(negedge clk);
        check("flush_valid", valid_out, 0);
        check("flush_ready", ready_out, 1);
        flush    = 1'b0;
        valid_in = 1'b0;
        ready_in = 1'b1;
        @(negedge clk);
        check("flush_no_deliver", valid_out, 0);

        ready_in = 1'b0;
        send(32'h00700393, 32'h600);
        valid_in = 1'b1;
        inst_in  = 32'h00800413;
        flush    = 1'b1;
        @(negedge clk);
        check("flush_one_valid", valid_out, 0);
        flush    = 1'b0;
        valid_in = 1'b0;
        ready_in = 1'b1;

        send(32'h00900493, 32'h680);
        valid_in = 1'b1;
        inst_in  = 32'h00A00513;
        pc_in    = 32'h684;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", valid_out, 0);
        check("async_rst_ready", ready_out, 0);
        check("async_rst_inst", inst_out, 0);
        valid_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rerst_ready", ready_out, 1);
        send(32'h00500113, 32'h700);
        check("post_rst_valid", valid_out, 1);
        check("post_rst_format", fmt, 5'b00001);
        check("post_rst_imm", imm, 32'h5);
        check("post_rst_pc", pc_out, 32'h700);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
